vga_scan: RTL
=============

VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_VIS 640 visible pixels per line
  H_FP 16 horizontal front porch
  H_SYNC 96 hsync width
  H_BP 48 horizontal back porch
  V_VIS 480 visible lines
  V_FP 10 vertical front porch
  V_SYNC 2 vsync width
  V_BP 33 vertical back porch
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_vga in 1 pixel clock, 25 MHz
  rst in 1 reset, asynchronous, active-high
  mapData in 8 pixel colour from the room map stage; one clk_vga registered latency from CurrentX/CurrentY
  CurrentX out 10 horizontal scan position to the map stage
  CurrentY out 9 vertical scan position to the map stage
  hsync out 1 horizontal sync, active-low
  vsync out 1 vertical sync, active-low
  rgb out 8 pixel colour to the DAC, RRRGGGBB
  video_on out 1 high while rgb carries a visible pixel
  frame_tick out 1 one-cycle pulse per frame
  frame_count out 8 free-running frame counter for animation
REQ-003 There is exactly one clock, clk_vga; all state uses it; rst is asynchronous and active-high.

Function
REQ-004 hcnt (10 bit) counts 0..H_TOTAL-1 (800) every cycle; it wraps to 0 after 799.
REQ-005 vcnt (10 bit) increments only when hcnt wraps; it counts 0..V_TOTAL-1 (525) and wraps to 0 after 524.
REQ-006 CurrentX is hcnt, driven directly from the register.
REQ-007 CurrentY is vcnt[8:0] when vcnt < V_VIS, else 0; it never wraps to an alias value.
REQ-008 Stage-0 visibility: vis0 = (hcnt < H_VIS) && (vcnt < V_VIS).
REQ-009 Stage-0 sync: hs0 is low for H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (656..751); vs0 is low for 490 <= vcnt < 492.
REQ-010 vis0, hs0 and vs0 pass through a 2-stage register pipeline (d1, d2); the d2 values drive video_on, hsync and vsync.
REQ-011 rgb is registered: on each edge rgb <= mapData when vis_d1 = 1, else 8'h00.
REQ-012 Consequence of REQ-010/011: rgb, hsync, vsync and video_on for the pixel at (hcnt, vcnt) appear together 2 cycles after that position is on CurrentX/CurrentY.
REQ-013 frame_tick is registered high for exactly one cycle, on the edge where hcnt 799 -> 0 and vcnt 524 -> 0.
REQ-014 frame_count increments by 1 on that same edge and wraps 255 -> 0.
REQ-015 Blanking: rgb is 8'h00 whenever video_on = 0, whatever mapData holds.
REQ-016 Parameter rule: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP and V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP; both SHALL be <= 1024.

Reset
REQ-017 While rst = 1 the following hold asynchronously:
  hcnt = vcnt = 0
  all d1/d2 pipeline registers inactive (vis = 0, hs = vs = 1)
  rgb = 0, hsync = vsync = 1, video_on = 0
  frame_tick = 0, frame_count = 0
REQ-018 After rst deasserts, the first edge advances hcnt to 1. The first full frame starts at (0,0) with no partial-frame artefacts.
REQ-019 rst asserted mid-frame aborts the frame immediately, with no sync glitch below the reset values; scanning restarts from (0,0).

Verification
REQ-020 Reset release, then 800 cycles:
  CurrentX sequence 0..799, 0
  CurrentY steps 0 -> 1 at the wrap
  hsync low for exactly 96 cycles, first low at the output 2 cycles after hcnt = 656
REQ-021 Run 420000 cycles (one frame):
  vsync low for exactly 2 lines (1600 cycles)
  frame_tick pulses once
  frame_count = 1
  CurrentY never exceeds 479
REQ-022 Hold mapData = 8'hB6 constant:
  rgb = 8'hB6 exactly while video_on = 1, i.e. 640 cycles per visible line
  rgb = 8'h00 in all porches and sync periods
REQ-023 Latency check with mapData modelled as a registered function of CurrentX (mapData = CurrentX[7:0] one cycle late): the rgb value on the first visible output cycle of each line is 8'h00, and the 640th is 8'h7F.
REQ-024 Run 256 frames: frame_count wraps 255 -> 0 and frame_tick still pulses exactly once per frame.
REQ-025 Assert rst at hcnt = 700, vcnt = 491 (inside hsync and vsync): hsync = vsync = 1 and rgb = 0 immediately; after release, hsync next goes low at output cycle 658.

Source files
------------

// File: rtl/vga_scan.sv
// vga_scan: VGA raster timing generator.
// Free-running pixel/line counters drive the map stage (CurrentX/CurrentY).
// Visibility and sync are decoded from the counters, then delayed two cycles.
// This delay keeps them aligned with the colour that the map stage returns
// one cycle later and that is registered here once more.
module vga_scan #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic [7:0] mapData,
    output logic [9:0] CurrentX,
    output logic [8:0] CurrentY,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       video_on,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    // Totals must fit the 10-bit counters (<= 1024).
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       hWrap;
    logic       vWrap;

    logic       vis0;
    logic       hs0;
    logic       vs0;

    logic       visD1;
    logic       hsD1;
    logic       vsD1;
    logic       visD2;
    logic       hsD2;
    logic       vsD2;

    // end-of-line / end-of-frame detection
    always_comb begin
        hWrap = (hcnt == H_LAST);
        vWrap = (vcnt == V_LAST);
    end

    // pixel and line counters; the line counter advances only on line wrap
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hWrap) begin
            hcnt <= '0;
            vcnt <= vWrap ? '0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // scan position to the map stage; blanking lines report row 0, never an alias
    always_comb begin
        CurrentX = hcnt;
        CurrentY = (vcnt < V_VIS_END) ? vcnt[8:0] : '0;
    end

    // stage-0 decode of visibility and active-low syncs
    always_comb begin
        vis0 = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
        hs0  = !((hcnt >= HS_START) && (hcnt < HS_END));
        vs0  = !((vcnt >= VS_START) && (vcnt < VS_END));
    end

    // two-stage timing pipeline; reset forces the inactive levels
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            visD1 <= 1'b0;
            hsD1  <= 1'b1;
            vsD1  <= 1'b1;
            visD2 <= 1'b0;
            hsD2  <= 1'b1;
            vsD2  <= 1'b1;
        end else begin
            visD1 <= vis0;
            hsD1  <= hs0;
            vsD1  <= vs0;
            visD2 <= visD1;
            hsD2  <= hsD1;
            vsD2  <= vsD1;
        end
    end

    // colour register: map data arrives one cycle late, so gate with the d1 visibility
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else begin
            rgb <= visD1 ? mapData : 8'h00;
        end
    end

    // frame pulse and animation counter, both on the frame-wrap edge
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_tick <= hWrap && vWrap;
            if (hWrap && vWrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // registered timing outputs
    always_comb begin
        video_on = visD2;
        hsync    = hsD2;
        vsync    = vsD2;
    end

endmodule
